// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter with a bounded lock for the single-ported 1K x 17
// data memory: one registered DM access per cycle, read data returned two cycles after grant.
module dm_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [9:0]  addr0,
    input  logic [9:0]  addr1,
    input  logic [16:0] wdata0,
    input  logic [16:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [16:0] rdata,
    output logic        dm_re,
    output logic        dm_we,
    output logic [9:0]  dm_addr,
    output logic [16:0] dm_wdata,
    input  logic [16:0] dm_rd_data
);
    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    logic        favor_q, favor_d;
    logic        lock_active_q, lock_active_d;
    logic        owner_q, owner_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        dm_re_q, dm_re_d;
    logic        dm_we_q, dm_we_d;
    logic [9:0]  dm_addr_q, dm_addr_d;
    logic [16:0] dm_wdata_q, dm_wdata_d;
    logic        tag_q, tag_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [16:0] rdata_q, rdata_d;

    logic        gnt0_c, gnt1_c, grant_any, gsel, g_we, g_lock, owner_lock;
    logic [9:0]  g_addr;
    logic [16:0] g_wdata;
    logic [7:0]  cnt_next;

    // While a lock is held only the owner can win, even when it is not requesting.
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (lock_active_q) begin
            gnt0_c = req0 & ~owner_q;
            gnt1_c = req1 &  owner_q;
        end else begin
            gnt0_c = req0 & (~req1 | ~favor_q);
            gnt1_c = req1 & (~req0 |  favor_q);
        end
    end

    // Grants are forced low in reset; the raw grant only feeds flops that reset holds anyway.
    assign gnt0 = gnt0_c & rst_n;
    assign gnt1 = gnt1_c & rst_n;

    assign grant_any  = gnt0_c | gnt1_c;
    assign gsel       = gnt1_c;
    assign g_we       = gsel ? we1    : we0;
    assign g_lock     = gsel ? lock1  : lock0;
    assign g_addr     = gsel ? addr1  : addr0;
    assign g_wdata    = gsel ? wdata1 : wdata0;
    assign owner_lock = owner_q ? lock1 : lock0;
    assign cnt_next   = !lock_active_q            ? 8'd1 :
                        (lock_cnt_q < MAX_LOCK_C) ? lock_cnt_q + 8'd1 : lock_cnt_q;

    always_comb begin
        favor_d       = favor_q;
        lock_active_d = lock_active_q;
        owner_d       = owner_q;
        lock_cnt_d    = lock_cnt_q;
        if (grant_any) begin
            if (g_lock) begin
                owner_d    = gsel;
                lock_cnt_d = cnt_next;
                if (cnt_next >= MAX_LOCK_C) begin
                    lock_active_d = 1'b0;
                    favor_d       = ~gsel;
                end else begin
                    lock_active_d = 1'b1;
                    if (!lock_active_q) favor_d = ~gsel;
                end
            end else begin
                lock_active_d = 1'b0;
                favor_d       = ~gsel;
            end
        end else if (lock_active_q && !owner_lock) begin
            lock_active_d = 1'b0;
        end
    end

    // Command stage issues the granted access; return stage captures DM data for reads.
    always_comb begin
        dm_re_d    = grant_any & ~g_we;
        dm_we_d    = grant_any &  g_we;
        dm_addr_d  = grant_any ? g_addr  : dm_addr_q;
        dm_wdata_d = grant_any ? g_wdata : dm_wdata_q;
        tag_d      = grant_any ? gsel    : tag_q;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        if (dm_re_q) begin
            rdata_d           = dm_rd_data;
            rvalid_d[tag_q]   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favor_q       <= 1'b0;
            lock_active_q <= 1'b0;
            owner_q       <= 1'b0;
            lock_cnt_q    <= 8'd0;
            dm_re_q       <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= 10'd0;
            dm_wdata_q    <= 17'd0;
            tag_q         <= 1'b0;
            rvalid_q      <= 2'b00;
            rdata_q       <= 17'd0;
        end else begin
            favor_q       <= favor_d;
            lock_active_q <= lock_active_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            dm_re_q       <= dm_re_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            tag_q         <= tag_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign dm_re    = dm_re_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign rvalid0  = rvalid_q[0];
    assign rvalid1  = rvalid_q[1];
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: per-cycle grant vectors plus scoreboards for DM commands
// and read responses, checked against a behavioural DM and a reference memory.
module tb_dm_arbiter;
    localparam int unsigned MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [9:0]  addr0, addr1;
    logic [16:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, dm_re, dm_we;
    logic [16:0] rdata, dm_wdata;
    logic [9:0]  dm_addr;
    logic [16:0] dm_rd_data = '0;

    dm_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rd_data(dm_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r0, w0, l0; logic [9:0] a0; logic [16:0] d0;
        logic r1, w1, l1; logic [9:0] a1; logic [16:0] d1;
        logic g0, g1;
    } vec_t;
    typedef struct { logic we; logic [9:0] addr; logic [16:0] wdata; int due; } cmd_t;
    typedef struct { logic port; logic [16:0] data; int due; } rsp_t;

    logic [16:0] dm_mem  [1024];
    logic [16:0] ref_mem [1024];
    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    vec_t        vecs[$];
    cmd_t        mc;
    rsp_t        mr;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Behavioural single-ported DM sampling on the falling edge.
    always @(negedge clk) begin
        if (dm_we) dm_mem[dm_addr] = dm_wdata;
        if (dm_re) dm_rd_data <= dm_mem[dm_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(logic r0, logic w0, logic [9:0] a0, logic [16:0] d0, logic l0,
                                logic r1, logic w1, logic [9:0] a1, logic [16:0] d1, logic l1,
                                logic g0, logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 10'h0, 17'h0, 0, 0, 0, 10'h0, 17'h0, 0, 0, 0);
    endfunction

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; lock0 = v.l0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; lock1 = v.l1;
    endtask

    // Apply one cycle of stimulus; expected traffic is derived from the vector, not the DUT.
    task automatic step(input vec_t v, input string tag);
        logic       p, w;
        logic [9:0] a;
        logic [16:0] d;
        drive(v);
        @(negedge clk);
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, v.g1, v.g0});
        if (v.g0 || v.g1) begin
            p = v.g1;
            w = p ? v.w1 : v.w0;
            a = p ? v.a1 : v.a0;
            d = p ? v.d1 : v.d0;
            cmd_q.push_back(cmd_t'{we: w, addr: a, wdata: d, due: cyc + 1});
            if (w) ref_mem[a] = d;
            else   rsp_q.push_back(rsp_t'{port: p, data: ref_mem[a], due: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: DM commands and read responses in grant order, at exact latency.
    always @(negedge clk) begin
        if (dm_re || dm_we) begin
            check("dm_exclusive", {31'd0, dm_re & dm_we}, 32'd0);
            if (cmd_q.size() == 0) begin
                check("dm_unexpected", {30'd0, dm_we, dm_re}, 32'd0);
            end else begin
                mc = cmd_q.pop_front();
                check("dm_cycle", cyc, mc.due);
                check("dm_we", {31'd0, dm_we}, {31'd0, mc.we});
                check("dm_addr", {22'd0, dm_addr}, {22'd0, mc.addr});
                if (mc.we) check("dm_wdata", {15'd0, dm_wdata}, {15'd0, mc.wdata});
            end
        end else if (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
            mc = cmd_q.pop_front();
            check("dm_missing", {30'd0, dm_we, dm_re}, mc.we ? 32'd2 : 32'd1);
        end

        if (rvalid0 || rvalid1) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                mr = rsp_q.pop_front();
                check("rsp_port", {30'd0, rvalid1, rvalid0}, mr.port ? 32'd2 : 32'd1);
                check("rsp_data", {15'd0, rdata}, {15'd0, mr.data});
                check("rsp_cycle", cyc, mr.due);
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mr = rsp_q.pop_front();
            check("rsp_missing", {30'd0, rvalid1, rvalid0}, mr.port ? 32'd2 : 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dm_mem[i]  = 17'((i * 37) ^ 32'h5A5);
            ref_mem[i] = 17'((i * 37) ^ 32'h5A5);
        end
        dm_mem[5]  = 17'h1ABCD;
        ref_mem[5] = 17'h1ABCD;

        // Reset with a request pending: grants forced low, all outputs cleared.
        drive(mk(1, 0, 10'h005, 17'h0, 0, 1, 0, 10'h006, 17'h0, 0, 0, 0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",      {30'd0, gnt1, gnt0},       32'd0);
        check("rst_rvalid",   {30'd0, rvalid1, rvalid0}, 32'd0);
        check("rst_rdata",    {15'd0, rdata},            32'd0);
        check("rst_dm_strb",  {30'd0, dm_we, dm_re},     32'd0);
        check("rst_dm_addr",  {22'd0, dm_addr},          32'd0);
        check("rst_dm_wdata", {15'd0, dm_wdata},         32'd0);
        drive(idle());
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read of the preloaded word.
        vecs.push_back(mk(1, 0, 10'h005, 17'h0, 0, 0, 0, 10'h000, 17'h0, 0, 1, 0));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Port 1 write at the top address, then read-after-write.
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 0, 1, 1, 10'h3FF, 17'h00042, 0, 0, 1));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 0, 1, 0, 10'h3FF, 17'h0, 0, 0, 1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Sustained dual reads alternate 0,1,0,1,0,1.
        vecs.push_back(mk(1, 0, 10'h010, 17'h0, 0, 1, 0, 10'h020, 17'h0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 10'h011, 17'h0, 0, 1, 0, 10'h020, 17'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 10'h011, 17'h0, 0, 1, 0, 10'h021, 17'h0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 10'h012, 17'h0, 0, 1, 0, 10'h021, 17'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 10'h012, 17'h0, 0, 1, 0, 10'h022, 17'h0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 10'h013, 17'h0, 0, 1, 0, 10'h022, 17'h0, 0, 0, 1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Cross-port: port 0 writes all-ones, port 1 reads it back the next cycle.
        vecs.push_back(mk(1, 1, 10'h010, 17'h1FFFF, 0, 1, 0, 10'h010, 17'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 0, 1, 0, 10'h010, 17'h0, 0, 0, 1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Port 1 lock: four grants, forced hand-off to port 0, lock re-honored, then released.
        vecs.push_back(mk(1, 0, 10'h030, 17'h0, 0, 1, 0, 10'h040, 17'h0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 10'h031, 17'h0, 0, 1, 0, 10'h040, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h031, 17'h0, 0, 1, 0, 10'h041, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h031, 17'h0, 0, 1, 0, 10'h042, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h031, 17'h0, 0, 1, 0, 10'h043, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h031, 17'h0, 0, 1, 0, 10'h044, 17'h0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 10'h032, 17'h0, 0, 1, 0, 10'h044, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h032, 17'h0, 0, 1, 0, 10'h045, 17'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 10'h032, 17'h0, 0, 1, 0, 10'h046, 17'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 10'h032, 17'h0, 0, 0, 0, 10'h000, 17'h0, 0, 1, 0));
        // Port 0 lock hold-off: owner idle with lock held blocks port 1 until lock drops.
        vecs.push_back(mk(1, 0, 10'h050, 17'h0, 1, 0, 0, 10'h000, 17'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 1, 1, 0, 10'h060, 17'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 1, 1, 0, 10'h060, 17'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 0, 1, 0, 10'h060, 17'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 17'h0, 0, 1, 0, 10'h060, 17'h0, 0, 0, 1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        vecs.push_back(idle());

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));
        check("drain_cmd", cmd_q.size(), 32'd0);
        check("drain_rsp", rsp_q.size(), 32'd0);

        // Reset in the cycle after a read grant: access suppressed, no response afterwards.
        step(mk(1, 0, 10'h005, 17'h0, 0, 0, 0, 10'h000, 17'h0, 0, 1, 0), "mid_rst");
        check("pre_rst_dm_re", {31'd0, dm_re}, 32'd1);
        rst_n = 1'b0;
        cmd_q.delete();
        rsp_q.delete();
        #1;
        check("mid_rst_gnt",     {30'd0, gnt1, gnt0},       32'd0);
        check("mid_rst_dm_strb", {30'd0, dm_we, dm_re},     32'd0);
        check("mid_rst_dm_addr", {22'd0, dm_addr},          32'd0);
        check("mid_rst_rdata",   {15'd0, rdata},            32'd0);
        check("mid_rst_rvalid",  {30'd0, rvalid1, rvalid0}, 32'd0);
        drive(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_rvalid%0d", i), {30'd0, rvalid1, rvalid0}, 32'd0);
            check($sformatf("post_rst_dm%0d", i),     {30'd0, dm_we, dm_re},     32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and sequencer for the single-ported 1K x 17 data memory (DM). It accepts read/write commands from two masters, such as the CPU load/store stage and a DMA/debug engine, using a req/gnt handshake. Arbitration is round-robin with an optional bounded lock. It drives exactly one DM access per cycle, then returns read data to the issuing port with a fixed two-cycle latency.

## Interface
Parameters:
- MAX_LOCK, 8: maximum consecutive grants a locking port may hold (1..255).

Ports:
- clk  in  1  system clock; DM samples on negedge, arbiter state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  command request; held until gnt.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  10  word address.
- wdata0, wdata1  in  17  write data.
- lock0, lock1  in  1  request to keep the grant on following cycles.
- gnt0, gnt1  out  1  combinational; the command is accepted at this posedge.
- rvalid0, rvalid1  out  1  one-cycle pulse; rdata is valid.
- rdata  out  17  registered read data, shared by both ports.
- dm_re, dm_we  out  1  DM strobes, registered, never both 1.
- dm_addr  out  10  DM address, registered.
- dm_wdata  out  17  DM write data, registered.
- dm_rd_data  in  17  DM read data, updated on negedge.

## Operation
- Grant rule: at most one of gnt0/gnt1 is 1. gnt0 = req0 & (~req1 | favor==0 | owner==0 lock active). gnt1 is symmetric.
- Lock override: if lock_active, only the owner may be granted. The other port waits even if the owner drops req.
- favor register (0/1): after any grant without lock_active, favor moves to the non-granted port.
- Lock entry: a grant with lockX=1 sets lock_active=1, owner=X, lock_cnt=1.
- Lock continuation: each further owner grant with lock held increments lock_cnt.
- Lock release: lock_active clears when any of these occurs:
  - the owner deasserts lock at the posedge;
  - lock_cnt reaches MAX_LOCK on a grant; favor is then forced to the other port;
  - owner req=0 and lock=0.
- Lock hold-off: if owner req=0 while lock=1, lock_active stays set. No grant is issued and lock_cnt is unchanged.
- Command stage (posedge after grant): dm_re=~weX, dm_we=weX, dm_addr=addrX, dm_wdata=wdataX, tag=X, and pend_rd=~weX. With no grant: dm_re=dm_we=0. dm_addr and dm_wdata hold their last value.
- Return stage: at the posedge after the command stage, if pend_rd then rdata<=dm_rd_data and rvalid[tag]<=1. Otherwise rvalid=0. rdata holds between reads.
- Ordering: commands complete in grant order. A read granted the cycle after a write to the same address returns the new data.
- Full throughput: one command per cycle, back-to-back, with either port mix.

## Timing
- Reset (async, rst_n=0): gnt0=gnt1=0 (forced), rvalid0=rvalid1=0, rdata=0, dm_re=dm_we=0, dm_addr=0, dm_wdata=0. Internal state: favor=0, lock_active=0, lock_cnt=0, pend_rd=0.
- Read latency: grant in cycle N → dm_re=1 in N+1 (DM reads at negedge N+1) → rvalid=1 and rdata valid in N+2.
- Write latency: grant in N → dm_we=1 in N+1; the memory is updated at negedge N+1. No response is returned.
- Simultaneous req0 & req1 with no lock: the favor port wins and favor flips. Sustained dual requests therefore alternate grants 0,1,0,1…
- Only the granted port sees gnt. A non-granted port must hold req/we/addr/wdata/lock stable.
- Reset mid-operation: in-flight commands are discarded and no rvalid is produced. A DM access already issued in the current cycle is suppressed because dm_re/dm_we clear immediately.
- lock_cnt width is 8 bits; it saturates at MAX_LOCK and never wraps.

## Test plan
- Reset, then req0 read addr 0x005 after DM holds 0x1ABCD at 0x005. Required: gnt0 in cycle N, dm_re=1 and dm_addr=0x005 in N+1, rvalid0=1 and rdata=0x1ABCD in N+2, rvalid1=0.
- Port 1 writes 0x00042 to 0x3FF in cycle N, then reads 0x3FF in N+1. Required: dm_we in N+1, dm_re in N+2, rvalid1 with rdata=0x00042 in N+3.
- req0 and req1 both held for 6 cycles with reads. Required: grants 0,1,0,1,0,1, and rvalid tags follow the same order two cycles later.
- MAX_LOCK=4; port 1 holds lock1 and req1 while req0 is held. Required: 4 gnt1, then gnt0, then favor returns and lock1 is re-honored.
- Port 0 holds lock0 but drops req0 for 2 cycles while req1=1. Required: no gnt1 during those 2 cycles. Then lock0 drops and gnt1 follows on the next cycle.
- Assert rst_n=0 in the cycle after a read grant. Required: outputs go to 0 immediately and no rvalid appears after reset release.
